// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM: fetch/decode/execute sequencing with
// memory handshake, wait-cycle timeout (bus error) and sticky error flags.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (op 000101) into BNEEX.
module mc_ctrl_fsm #(
    parameter int unsigned ALUCTL_W = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                memready,
    output logic                pcen,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                alusrca,
    output logic                iord,
    output logic                memtoreg,
    output logic                regdst,
    output logic                memreq,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                illegal,
    output logic                buserr,
    output logic [3:0]          state
);

    localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_CTRL_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             buserr_q, buserr_d;
    logic             req_state;
    logic             timeout;
    logic [2:0]       alu_rt;
    logic             funct_ok;

    // A timed-out request is abandoned in the cycle after WAIT_MAX wait cycles
    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout   = req_state && (WAIT_MAX != 0) && (wait_q == CNT_W'(WAIT_MAX));

    // R-type funct to ALU operation; funct_ok=0 flags an unsupported funct
    always_comb begin
        alu_rt   = ALU_AND;
        funct_ok = 1'b1;
        case (funct)
            6'b100000: alu_rt = ALU_ADD;
            6'b100010: alu_rt = ALU_SUB;
            6'b100100: alu_rt = ALU_AND;
            6'b100101: alu_rt = ALU_OR;
            6'b101010: alu_rt = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Next-state, error flags and datapath strobes; everything quiet while in reset
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        buserr_d   = buserr_q;
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        memreq     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = '0;
        if (reset) begin
            if (timeout) begin
                state_d  = S_FETCH;
                buserr_d = 1'b1;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        memreq     = 1'b1;
                        alusrcb    = 2'b01;
                        alucontrol = ALUCTL_W'(ALU_ADD);
                        if (memready) begin
                            irwrite = 1'b1;
                            pcen    = 1'b1;
                            state_d = S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        alusrcb    = 2'b11;
                        alucontrol = ALUCTL_W'(ALU_ADD);
                        case (op)
                            6'b000000:            state_d = S_RTYPEEX;
                            6'b100011, 6'b101011: state_d = S_MEMADR;
                            6'b000100:            state_d = S_BEQEX;
`ifdef MC_CTRL_BNE_EN
                            6'b000101:            state_d = S_BNEEX;
`endif
                            6'b001000:            state_d = S_ADDIEX;
                            6'b000010:            state_d = S_JEX;
                            default: begin
                                illegal_d = 1'b1;
                                state_d   = S_FETCH;
                            end
                        endcase
                    end
                    S_MEMADR: begin
                        alusrca    = 1'b1;
                        alusrcb    = 2'b10;
                        alucontrol = ALUCTL_W'(ALU_ADD);
                        state_d    = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
                    end
                    S_MEMRD: begin
                        memreq = 1'b1;
                        iord   = 1'b1;
                        if (memready) state_d = S_MEMWB;
                    end
                    S_MEMWB: begin
                        regwrite = 1'b1;
                        memtoreg = 1'b1;
                        state_d  = S_FETCH;
                    end
                    S_MEMWR: begin
                        memreq   = 1'b1;
                        memwrite = 1'b1;
                        iord     = 1'b1;
                        if (memready) state_d = S_FETCH;
                    end
                    S_RTYPEEX: begin
                        alusrca = 1'b1;
                        if (funct_ok) begin
                            alucontrol = ALUCTL_W'(alu_rt);
                            state_d    = S_RTYPEWB;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    S_RTYPEWB: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    S_BEQEX: begin
                        alusrca    = 1'b1;
                        alucontrol = ALUCTL_W'(ALU_SUB);
                        pcsrc      = 2'b01;
                        pcen       = zero;
                        state_d    = S_FETCH;
                    end
`ifdef MC_CTRL_BNE_EN
                    S_BNEEX: begin
                        alusrca    = 1'b1;
                        alucontrol = ALUCTL_W'(ALU_SUB);
                        pcsrc      = 2'b01;
                        pcen       = ~zero;
                        state_d    = S_FETCH;
                    end
`endif
                    S_ADDIEX: begin
                        alusrca    = 1'b1;
                        alusrcb    = 2'b10;
                        alucontrol = ALUCTL_W'(ALU_ADD);
                        state_d    = S_ADDIWB;
                    end
                    S_ADDIWB: begin
                        regwrite = 1'b1;
                        state_d  = S_FETCH;
                    end
                    S_JEX: begin
                        pcsrc   = 2'b10;
                        pcen    = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
        end
    end

    // Consecutive wait-cycle counter; restarts whenever the request ends
    always_comb begin
        wait_d = wait_q;
        if (timeout || (state_d != state_q)) begin
            wait_d = '0;
        end else if ((WAIT_MAX != 0) && memreq && !memready) begin
            wait_d = wait_q + CNT_W'(1);
        end
    end

    // State, wait counter and sticky flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            buserr_q  <= buserr_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign buserr  = buserr_q;

endmodule
